// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly stage: x = a + w*b, y = a - w*b on signed Q2.14 operands.
// Three-stage valid/ready pipeline with frame-last tagging and optional halving or saturation.
module fft_butterfly_stage #(
    parameter int unsigned SCALE = 1,
    parameter int unsigned LOG2N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] a_re,
    input  logic signed [15:0] a_im,
    input  logic signed [15:0] b_re,
    input  logic signed [15:0] b_im,
    input  logic signed [15:0] w_re,
    input  logic signed [15:0] w_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] x_re,
    output logic signed [15:0] x_im,
    output logic signed [15:0] y_re,
    output logic signed [15:0] y_im,
    output logic               out_last,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam logic [LOG2N-1:0] IdxMax = '1;

    logic             stall;
    logic [LOG2N-1:0] idx;

    logic               v1, last1;
    logic signed [15:0] a1_re, a1_im, b1_re, b1_im, w1_re, w1_im;

    logic               v2, last2;
    logic signed [15:0] a2_re, a2_im, p_re, p_im;

    logic signed [31:0] m_rr, m_ii, m_ri, m_ir, p_re_full, p_im_full;
    logic signed [16:0] sx_re, sx_im, sy_re, sy_im;
    logic        [15:0] x_re_d, x_im_d, y_re_d, y_im_d;
    logic               sat_hit;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Full 32-bit products wrap; >>>14 followed by keeping 16 bits selects [29:14].
    assign m_rr      = w1_re * b1_re;
    assign m_ii      = w1_im * b1_im;
    assign m_ri      = w1_re * b1_im;
    assign m_ir      = w1_im * b1_re;
    assign p_re_full = m_rr - m_ii;
    assign p_im_full = m_ri + m_ir;

    assign sx_re = {a2_re[15], a2_re} + {p_re[15], p_re};
    assign sx_im = {a2_im[15], a2_im} + {p_im[15], p_im};
    assign sy_re = {a2_re[15], a2_re} - {p_re[15], p_re};
    assign sy_im = {a2_im[15], a2_im} - {p_im[15], p_im};

    function automatic logic ovr17(input logic [16:0] v);
        return v[16] != v[15];
    endfunction

    function automatic logic [15:0] sat17(input logic [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'h8000 : 16'h7fff;
        end
        return v[15:0];
    endfunction

    always_comb begin
        x_re_d  = sx_re[16:1];
        x_im_d  = sx_im[16:1];
        y_re_d  = sy_re[16:1];
        y_im_d  = sy_im[16:1];
        sat_hit = 1'b0;
        if (SCALE == 0) begin
            x_re_d  = sat17(sx_re);
            x_im_d  = sat17(sx_im);
            y_re_d  = sat17(sy_re);
            y_im_d  = sat17(sy_im);
            sat_hit = ovr17(sx_re) || ovr17(sx_im) || ovr17(sy_re) || ovr17(sy_im);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            v1        <= 1'b0;
            last1     <= 1'b0;
            a1_re     <= '0;
            a1_im     <= '0;
            b1_re     <= '0;
            b1_im     <= '0;
            w1_re     <= '0;
            w1_im     <= '0;
            v2        <= 1'b0;
            last2     <= 1'b0;
            a2_re     <= '0;
            a2_im     <= '0;
            p_re      <= '0;
            p_im      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
        end else if (!stall) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1_re <= a_re;
                a1_im <= a_im;
                b1_re <= b_re;
                b1_im <= b_im;
                w1_re <= w_re;
                w1_im <= w_im;
                last1 <= (idx == IdxMax);
                idx   <= idx + 1'b1;
            end
            v2 <= v1;
            if (v1) begin
                a2_re <= a1_re;
                a2_im <= a1_im;
                p_re  <= p_re_full[29:14];
                p_im  <= p_im_full[29:14];
                last2 <= last1;
            end
            out_valid <= v2;
            out_last  <= v2 && last2;
            if (v2) begin
                x_re <= x_re_d;
                x_im <= x_im_d;
                y_re <= y_re_d;
                y_im <= y_im_d;
            end
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (!stall && v2 && sat_hit) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Scoreboard bench: one SCALE=1 and one SCALE=0 instance share stimulus and out_ready;
// expected results come from a plain-integer butterfly model.
module tb_fft_butterfly_stage;

    localparam int LOG2N = 3;
    localparam int NFR   = 1 << LOG2N;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, out_ready, ovf_clr;
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;

    logic in_ready1, out_valid1, out_last1, ovf1;
    logic in_ready0, out_valid0, out_last0, ovf0;
    logic signed [15:0] x1_re, x1_im, y1_re, y1_im;
    logic signed [15:0] x0_re, x0_im, y0_re, y0_im;

    always #5 clk = ~clk;

    fft_butterfly_stage #(.SCALE(1), .LOG2N(LOG2N)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid1), .out_ready(out_ready),
        .x_re(x1_re), .x_im(x1_im), .y_re(y1_re), .y_im(y1_im),
        .out_last(out_last1), .ovf(ovf1), .ovf_clr(ovf_clr)
    );

    fft_butterfly_stage #(.SCALE(0), .LOG2N(LOG2N)) u_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .x_re(x0_re), .x_im(x0_im), .y_re(y0_re), .y_im(y0_im),
        .out_last(out_last0), .ovf(ovf0), .ovf_clr(ovf_clr)
    );

    typedef struct {
        int x1r, x1i, y1r, y1i;
        int x0r, x0i, y0r, y0i;
        bit last;
        bit ovf0;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int acc_cnt;
    bit ovf_model;
    int n_last, n_stall;
    int lx1r, lx1i, ly1r, ly1i, lx0r, lx0i, ly0r, ly0i;
    int mode = 0;
    int cyc  = 0;
    int st0  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic int halve(input int s);
        return s >>> 1;
    endfunction

    function automatic int clamp(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic bit clipped(input int s);
        return (s > 32767) || (s < -32768);
    endfunction

    // out_ready policy: 0 always ready, 1 random, 2 four-cycle stall window at st0.
    always @(posedge clk) begin
        #1;
        case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !(cyc >= st0 && cyc < st0 + 4);
            default: out_ready = 1'b1;
        endcase
        cyc++;
    end

    // Stimulus side of the scoreboard: model each accepted set.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_cnt   = 0;
            ovf_model = 1'b0;
            q.delete();
        end else begin
            if (ovf_clr) ovf_model = 1'b0;
            if (in_valid && in_ready1) begin
                exp_t e;
                int pr, pi, sxr, sxi, syr, syi;
                pr  = wrap16((int'(w_re) * int'(b_re) - int'(w_im) * int'(b_im)) >>> 14);
                pi  = wrap16((int'(w_re) * int'(b_im) + int'(w_im) * int'(b_re)) >>> 14);
                sxr = int'(a_re) + pr;
                sxi = int'(a_im) + pi;
                syr = int'(a_re) - pr;
                syi = int'(a_im) - pi;
                e.x1r = halve(sxr); e.x1i = halve(sxi);
                e.y1r = halve(syr); e.y1i = halve(syi);
                e.x0r = clamp(sxr); e.x0i = clamp(sxi);
                e.y0r = clamp(syr); e.y0i = clamp(syi);
                if (clipped(sxr) || clipped(sxi) || clipped(syr) || clipped(syi))
                    ovf_model = 1'b1;
                e.ovf0 = ovf_model;
                e.last = (acc_cnt % NFR) == NFR - 1;
                acc_cnt++;
                q.push_back(e);
            end
        end
    end

    // Monitor side: compare whenever an output is presented; a stalled output must stay put.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_last = 0;
        end else begin
            check("in_ready", int'(in_ready1), int'(!(out_valid1 && !out_ready)));
            check("in_ready_s0", int'(in_ready0), int'(!(out_valid1 && !out_ready)));
            check("ovf_scaled", int'(ovf1), 0);
            if (!in_ready1) n_stall++;
            if (!out_valid1) begin
                check("last_idle", int'(out_last1), 0);
                check("valid_s0_idle", int'(out_valid0), 0);
            end else if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q[0];
                check("valid_s0", int'(out_valid0), 1);
                check("x1_re", int'(x1_re), e.x1r);
                check("x1_im", int'(x1_im), e.x1i);
                check("y1_re", int'(y1_re), e.y1r);
                check("y1_im", int'(y1_im), e.y1i);
                check("x0_re", int'(x0_re), e.x0r);
                check("x0_im", int'(x0_im), e.x0i);
                check("y0_re", int'(y0_re), e.y0r);
                check("y0_im", int'(y0_im), e.y0i);
                check("last1", int'(out_last1), int'(e.last));
                check("last0", int'(out_last0), int'(e.last));
                check("ovf0", int'(ovf0), int'(e.ovf0));
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e.last) n_last++;
                    lx1r = x1_re; lx1i = x1_im; ly1r = y1_re; ly1i = y1_im;
                    lx0r = x0_re; lx0i = x0_im; ly0r = y0_re; ly0i = y0_im;
                end
            end
        end
    end

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi);
        bit ok;
        a_re = 16'(ar); a_im = 16'(ai);
        b_re = 16'(br); b_im = 16'(bi);
        w_re = 16'(wr); w_im = 16'(wi);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    function automatic int rnd16();
        case ($urandom_range(0, 5))
            0:       return 32767;
            1:       return -32768;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    task automatic drain();
        mode     = 0;
        in_valid = 1'b0;
        for (int k = 0; k < 200 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_left", q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_valid", int'(out_valid1), 0);
        check("rst_valid_s0", int'(out_valid0), 0);
        check("rst_x", int'(x1_re), 0);
        check("rst_y0", int'(y0_im), 0);
        check("rst_last", int'(out_last1), 0);
        check("rst_ovf", int'(ovf0), 0);
        check("rst_in_ready", int'(in_ready1), 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lasts;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        a_re = 0; a_im = 0; b_re = 0; b_im = 0; w_re = 0; w_im = 0;
        n_stall  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("init_valid", int'(out_valid1), 0);
        check("init_in_ready", int'(in_ready1), 1);
        check("init_ovf", int'(ovf0), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reference vectors.
        send(1000, 0, 16384, 0, 16384, 0);
        drain();
        check("v1_x_re", lx1r, 8692);
        check("v1_x_im", lx1i, 0);
        check("v1_y_re", ly1r, -7692);
        check("v1_y_im", ly1i, 0);
        send(0, 0, 16384, 0, 0, -16384);
        drain();
        check("v2_x_im", lx1i, -8192);
        check("v2_y_im", ly1i, 8192);
        check("v2_x_re", lx1r, 0);
        send(30000, 0, 16384, 0, 16384, 0);
        drain();
        check("v3_x_re", lx0r, 32767);
        check("v3_y_re", ly0r, 13616);
        check("v3_ovf", int'(ovf0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("v3_ovf_sticky", int'(ovf0), 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("v3_ovf_clr", int'(ovf0), 0);

        // Backpressure: 8 back-to-back sets, four-cycle stall mid-stream.
        lasts = n_stall;
        st0   = cyc + 5;
        mode  = 2;
        for (int i = 0; i < 8; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        drain();
        check("stall_cycles", n_stall - lasts, 4);

        // Frame marking: 16 sets from a clean reset give two lasts.
        pulse_reset();
        for (int i = 0; i < 16; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        drain();
        check("frame_lasts", n_last, 2);

        // Reset mid-frame discards in-flight sets and restarts indexing.
        for (int i = 0; i < 5; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        pulse_reset();
        for (int i = 0; i < 8; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        drain();
        check("frame_after_reset", n_last, 1);

        // Random traffic with bubbles and random backpressure.
        mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
